price_level_book: RTL and testbench
===================================

Name: price_level_book

Overview:
- Parametrised, price-level-aggregated half book. It is the successor to the single-level order book.
- Holds one aggregate quantity per price level, for NUM_LEVELS = 2**PRICE_W levels.
- Applies ADD, CANCEL and EXECUTE requests one at a time under a start/busy handshake.
- Maintains best price and best quantity. When the best level empties, it performs a sequential best-price rescan. Instantiated once per side: bid with IS_MAX=1, ask with IS_MAX=0.

Parameters:
- IS_MAX, 1: 1 means best is the highest non-empty price (bid); 0 means the lowest (ask).
- PRICE_W, 8: price width in bits; NUM_LEVELS = 2**PRICE_W.
- QTY_W, 16: request quantity width.
- LVL_W, 24: per-level aggregate quantity width; must be >= QTY_W.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only while busy=0.
- request  in  2  operation: 0=ADD, 1=CANCEL, 2=EXECUTE, 3=invalid.
- price  in  PRICE_W  target level.
- quantity  in  QTY_W  request quantity.
- busy  out  1  request in progress.
- done  out  1  one-cycle completion pulse.
- done_qty  out  LVL_W  quantity actually applied; valid with done.
- err  out  1  error flag; valid with done.
- best_price  out  PRICE_W  current best level.
- best_qty  out  LVL_W  aggregate quantity at best_price.
- best_valid  out  1  book non-empty.
- level_count  out  PRICE_W+1  number of non-zero levels.

Behaviour:
- Reset (rst_in=1 at a clock edge):
  - All levels cleared, state IDLE.
  - busy, done, err, best_valid = 0; done_qty, best_price, best_qty, level_count = 0.
  - Reset overrides any in-flight update or scan; the request is dropped and no done pulse is issued.
- States: IDLE, UPDATE, SCAN.
- IDLE:
  - On start=1 at edge T: latch request, price and quantity; go to UPDATE; busy=1 from T+1.
  - start while busy=1 is ignored (no queueing, no err).
- UPDATE (cycle T+1), single read-modify-write of level[price]:
  - ADD:
    - new = level + quantity, saturating at 2**LVL_W-1.
    - On saturation: err=1 and done_qty = amount actually added. Otherwise done_qty = quantity.
    - If the level was 0, level_count increments.
    - If best_valid=0, or price is strictly better than best_price (greater for IS_MAX=1, less for IS_MAX=0): best_price=price.
    - best_qty tracks level[best_price] after the write.
  - CANCEL / EXECUTE (identical level arithmetic):
    - applied = min(quantity, level); level -= applied; done_qty = applied. Clamping is silent, err=0.
    - If the level was already 0, or quantity=0: no change, done_qty=0, err=1.
    - If the level becomes 0, level_count decrements.
    - If that level was best_price, go to SCAN with scan_ptr = best_price-1 (IS_MAX=1) or best_price+1 (IS_MAX=0).
    - If best_price is at the array edge, skip SCAN and declare the book empty.
  - request=3: no change, err=1.
  - If no scan is needed, return to IDLE: done=1 and busy=0 at T+2.
- SCAN:
  - Examines one level per cycle at scan_ptr.
  - On a non-zero level: best_price=scan_ptr, best_qty=level; done=1 and busy=0 on the following edge.
  - On a zero level, scan_ptr steps toward worse prices. After examining price 0 (bid) or NUM_LEVELS-1 (ask) without a hit: best_valid=0, best_price=0, best_qty=0, then done.
  - Latency: done at T+2+k, where k is the number of levels examined; worst case k = NUM_LEVELS-1.
- Output timing:
  - best_price, best_qty, best_valid and level_count are registered. They change only on the edge that raises done, or on reset.
  - best_valid equals (level_count != 0) at all times.
- Priority on a simultaneous edge: rst_in > in-flight operation > start.

Test Plan (IS_MAX=1, PRICE_W=8, QTY_W=16, LVL_W=24):
- Reset, then idle 5 cycles -> all outputs 0; busy=0, best_valid=0.
- ADD(100,50), ADD(105,20), ADD(103,10), each started when busy=0 -> each done exactly 2 cycles after start, err=0. Final state: best_price=105, best_qty=20, level_count=3.
- EXECUTE(105,20) started at T -> done at T+4 (scans 104, then 103), done_qty=20. Result: best_price=103, best_qty=10, level_count=2.
- CANCEL(100,80) -> done at T+2, done_qty=50, err=0, level_count=1, best unchanged at 103. Then CANCEL(100,5) -> err=1, done_qty=0.
- CANCEL(103,10) -> scans 102..0 (k=103), done at T+105. Result: best_valid=0, best_price=0, level_count=0.
- ADD(7,0xFFFF) repeated 257 times -> final add saturates level at 0xFFFFFF, err=1, done_qty=0xFFFFFF-0xFFFF*256. start pulses during busy=1 are ignored. Then start another scan and assert rst_in mid-SCAN -> no done pulse, all outputs 0 next cycle.

Source files
------------

// File: rtl/price_level_book.sv
// price_level_book
//   One side of a price-level-aggregated book. Each of the 2**PRICE_W price
//   levels holds one aggregate quantity. ADD / CANCEL / EXECUTE requests are
//   applied one at a time under a start/busy handshake. The best level is kept
//   incrementally. When the best level empties, the next best is found by
//   stepping one level per cycle toward worse prices.
//
// Ports
//   clk_in       clock
//   rst_in       synchronous active-high reset; clears every level and drops
//                any request in flight
//   start        request strobe, only looked at while busy=0
//   request      0=ADD, 1=CANCEL, 2=EXECUTE, 3=invalid
//   price        target level
//   quantity     request quantity
//   busy         request in progress
//   done         one-cycle completion pulse
//   done_qty     quantity actually applied (valid with done)
//   err          error flag (valid with done)
//   best_price   current best level (highest for IS_MAX=1, lowest otherwise)
//   best_qty     aggregate quantity at best_price
//   best_valid   book holds at least one non-empty level
//   level_count  number of non-empty levels
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; request fields are latched on the start edge
// UPDATE | one read-modify-write of the latched level, best kept up to date
// SCAN   | best level emptied; examine scan_ptr, one level per cycle
module price_level_book #(
  parameter bit IS_MAX  = 1'b1,
  parameter int PRICE_W = 8,
  parameter int QTY_W   = 16,
  parameter int LVL_W   = 24
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start,
  input  logic [1:0]         request,
  input  logic [PRICE_W-1:0] price,
  input  logic [QTY_W-1:0]   quantity,
  output logic               busy,
  output logic               done,
  output logic [LVL_W-1:0]   done_qty,
  output logic               err,
  output logic [PRICE_W-1:0] best_price,
  output logic [LVL_W-1:0]   best_qty,
  output logic               best_valid,
  output logic [PRICE_W:0]   level_count
);

  localparam int NUM_LEVELS = 2**PRICE_W;

  localparam logic [1:0] REQ_ADD     = 2'd0;
  localparam logic [1:0] REQ_CANCEL  = 2'd1;
  localparam logic [1:0] REQ_EXECUTE = 2'd2;

  localparam logic [LVL_W-1:0]   LVL_MAX   = {LVL_W{1'b1}};
  localparam logic [PRICE_W-1:0] PRICE_ONE = {{(PRICE_W-1){1'b0}}, 1'b1};
  localparam logic [PRICE_W:0]   CNT_ONE   = {{PRICE_W{1'b0}}, 1'b1};

  // Worst price on this side: the scan gives up after examining it.
  localparam logic [PRICE_W-1:0] EDGE_PRICE = IS_MAX ? {PRICE_W{1'b0}} : {PRICE_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_SCAN
  } state_t;

  state_t state_q, state_d;

  logic [LVL_W-1:0]   level_mem [NUM_LEVELS];

  logic [1:0]         req_q,        req_d;
  logic [PRICE_W-1:0] price_q,      price_d;
  logic [QTY_W-1:0]   qty_q,        qty_d;
  logic [PRICE_W-1:0] scan_ptr_q,   scan_ptr_d;
  logic               busy_q,       busy_d;
  logic               done_q,       done_d;
  logic [LVL_W-1:0]   done_qty_q,   done_qty_d;
  logic               err_q,        err_d;
  logic [PRICE_W-1:0] best_price_q, best_price_d;
  logic [LVL_W-1:0]   best_qty_q,   best_qty_d;
  logic               best_valid_q, best_valid_d;
  logic [PRICE_W:0]   level_count_q, level_count_d;
  // Live count of non-empty levels; level_count only follows it on done so the
  // published view never moves in the middle of a scan.
  logic [PRICE_W:0]   cnt_q,        cnt_d;

  logic               mem_we;
  logic [LVL_W-1:0]   mem_wdata;
  logic [LVL_W-1:0]   new_lvl;

  logic [LVL_W-1:0]   lvl_rd;
  logic [LVL_W-1:0]   scan_rd;
  logic [LVL_W-1:0]   qty_ext;
  logic [LVL_W:0]     sum_ext;
  logic [LVL_W-1:0]   take;
  logic               better;

  assign lvl_rd  = level_mem[price_q];
  assign scan_rd = level_mem[scan_ptr_q];
  assign qty_ext = LVL_W'(qty_q);
  assign sum_ext = {1'b0, lvl_rd} + {1'b0, qty_ext};
  assign take    = (qty_ext < lvl_rd) ? qty_ext : lvl_rd;
  assign better  = IS_MAX ? (price_q > best_price_q) : (price_q < best_price_q);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    price_d       = price_q;
    qty_d         = qty_q;
    scan_ptr_d    = scan_ptr_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    done_qty_d    = done_qty_q;
    err_d         = err_q;
    best_price_d  = best_price_q;
    best_qty_d    = best_qty_q;
    best_valid_d  = best_valid_q;
    level_count_d = level_count_q;
    cnt_d         = cnt_q;
    mem_we        = 1'b0;
    mem_wdata     = lvl_rd;
    new_lvl       = lvl_rd;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_UPDATE;
          busy_d  = 1'b1;
          req_d   = request;
          price_d = price;
          qty_d   = quantity;
        end
      end

      ST_UPDATE: begin
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        err_d      = 1'b0;
        done_qty_d = '0;

        case (req_q)
          REQ_ADD: begin
            if (sum_ext[LVL_W]) begin
              new_lvl    = LVL_MAX;
              done_qty_d = LVL_MAX - lvl_rd;
              err_d      = 1'b1;
            end else begin
              new_lvl    = sum_ext[LVL_W-1:0];
              done_qty_d = qty_ext;
            end
            mem_we    = 1'b1;
            mem_wdata = new_lvl;
            // A zero-quantity add to an empty level leaves it empty, so it must
            // neither count as a new level nor become best.
            if (lvl_rd == '0 && new_lvl != '0) begin
              cnt_d = cnt_q + CNT_ONE;
            end
            if (new_lvl != '0) begin
              if (!best_valid_q || better) begin
                best_price_d = price_q;
                best_qty_d   = new_lvl;
              end else if (price_q == best_price_q) begin
                best_qty_d = new_lvl;
              end
            end
          end

          REQ_CANCEL, REQ_EXECUTE: begin
            if (lvl_rd == '0 || qty_q == '0) begin
              err_d = 1'b1;
            end else begin
              new_lvl    = lvl_rd - take;
              done_qty_d = take;
              mem_we     = 1'b1;
              mem_wdata  = new_lvl;
              if (new_lvl == '0) begin
                cnt_d = cnt_q - CNT_ONE;
              end
              // A non-empty level implies best_valid, so the price match alone
              // identifies the best level.
              if (price_q == best_price_q) begin
                if (new_lvl != '0) begin
                  best_qty_d = new_lvl;
                end else if (best_price_q == EDGE_PRICE) begin
                  best_price_d = '0;
                  best_qty_d   = '0;
                end else begin
                  state_d    = ST_SCAN;
                  busy_d     = 1'b1;
                  done_d     = 1'b0;
                  scan_ptr_d = IS_MAX ? (best_price_q - PRICE_ONE)
                                      : (best_price_q + PRICE_ONE);
                end
              end
            end
          end

          default: begin
            err_d = 1'b1;
          end
        endcase
      end

      ST_SCAN: begin
        if (scan_rd != '0) begin
          best_price_d = scan_ptr_q;
          best_qty_d   = scan_rd;
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
        end else if (scan_ptr_q == EDGE_PRICE) begin
          best_price_d = '0;
          best_qty_d   = '0;
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
        end else begin
          scan_ptr_d = IS_MAX ? (scan_ptr_q - PRICE_ONE) : (scan_ptr_q + PRICE_ONE);
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Count and validity are published together with done only.
    if (done_d) begin
      level_count_d = cnt_d;
      best_valid_d  = (cnt_d != '0);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_LEVELS; i++) begin
        level_mem[i] <= '0;
      end
    end else if (mem_we) begin
      level_mem[price_q] <= mem_wdata;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      req_q         <= '0;
      price_q       <= '0;
      qty_q         <= '0;
      scan_ptr_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      done_qty_q    <= '0;
      err_q         <= 1'b0;
      best_price_q  <= '0;
      best_qty_q    <= '0;
      best_valid_q  <= 1'b0;
      level_count_q <= '0;
      cnt_q         <= '0;
    end else begin
      req_q         <= req_d;
      price_q       <= price_d;
      qty_q         <= qty_d;
      scan_ptr_q    <= scan_ptr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      done_qty_q    <= done_qty_d;
      err_q         <= err_d;
      best_price_q  <= best_price_d;
      best_qty_q    <= best_qty_d;
      best_valid_q  <= best_valid_d;
      level_count_q <= level_count_d;
      cnt_q         <= cnt_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign done_qty    = done_qty_q;
  assign err         = err_q;
  assign best_price  = best_price_q;
  assign best_qty    = best_qty_q;
  assign best_valid  = best_valid_q;
  assign level_count = level_count_q;

endmodule

// File: tb/tb_price_level_book.sv
// Bench for price_level_book as a bid side (IS_MAX=1, 256 levels).
module tb_price_level_book;

  localparam longint LVL_MAXV = 64'd16777215;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  request = 2'd0;
  logic [7:0]  price = 8'd0;
  logic [15:0] quantity = 16'd0;
  logic        busy;
  logic        done;
  logic [23:0] done_qty;
  logic        err;
  logic [7:0]  best_price;
  logic [23:0] best_qty;
  logic        best_valid;
  logic [8:0]  level_count;

  price_level_book #(
    .IS_MAX (1'b1),
    .PRICE_W(8),
    .QTY_W  (16),
    .LVL_W  (24)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .start      (start),
    .request    (request),
    .price      (price),
    .quantity   (quantity),
    .busy       (busy),
    .done       (done),
    .done_qty   (done_qty),
    .err        (err),
    .best_price (best_price),
    .best_qty   (best_qty),
    .best_valid (best_valid),
    .level_count(level_count)
  );

  always #5 clk_in = ~clk_in;

  int n_pass = 0;
  int n_total = 0;

  // Results of the most recent run_op.
  int     r_lat;
  longint r_dq;
  int     r_err;
  int     r_busy;
  int     r_idle;
  int     r_stable;
  int     r_pulse;

  // Reference book: plain array of aggregate quantities.
  longint lvl_m [256];

  typedef struct {
    int op; int p; int q;
    int lat; longint dq; int err;
    int bp; longint bq; int bv; int cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic chk_best(input string tag, input int bp, input longint bq, input int bv, input int cnt);
    chk({tag, " best_price"}, longint'(best_price), longint'(bp));
    chk({tag, " best_qty"}, longint'(best_qty), bq);
    chk({tag, " best_valid"}, longint'(best_valid), longint'(bv));
    chk({tag, " level_count"}, longint'(level_count), longint'(cnt));
  endtask

  // Issue one request and follow it to done (bounded). Latency is counted in
  // cycles with the start cycle as cycle 0, so a plain update reports 2.
  task automatic run_op(input int op, input int p, input int q, input bit poke);
    int bp0, bq0, bv0, cnt0;
    bit got;
    @(negedge clk_in);
    start = 1'b1; request = 2'(op); price = 8'(p); quantity = 16'(q);
    bp0 = int'(best_price); bq0 = int'(best_qty); bv0 = int'(best_valid); cnt0 = int'(level_count);
    @(posedge clk_in); #1;
    start = 1'b0;
    r_busy = int'(busy);
    r_lat = 1; got = 1'b0; r_stable = 1; r_dq = 0; r_err = 0; r_idle = 0; r_pulse = 1;
    if (poke) begin
      // A better-priced ADD presented while busy must be dropped.
      start = 1'b1; request = 2'd0; price = 8'd200; quantity = 16'd1;
    end
    while (!got && r_lat < 400) begin
      @(posedge clk_in); #1;
      start = 1'b0;
      r_lat++;
      if (done) begin
        got = 1'b1; r_dq = longint'(done_qty); r_err = int'(err); r_idle = int'(!busy);
      end else if (int'(best_price) != bp0 || int'(best_qty) != bq0 ||
                   int'(best_valid) != bv0 || int'(level_count) != cnt0) begin
        r_stable = 0;
      end
    end
    @(posedge clk_in); #1;
    if (done) r_pulse = 0;
  endtask

  task automatic model_best(output int bp, output longint bq, output int bv, output int cnt);
    bp = 0; bq = 0; bv = 0; cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (lvl_m[i] != 0) begin
        cnt++;
        bp = i; bq = lvl_m[i]; bv = 1;
      end
    end
  endtask

  initial begin
    int bad;
    int seen;

    vecs[0]  = '{0, 100, 50,    2,  50, 0, 100, 50, 1, 1};
    vecs[1]  = '{0, 105, 20,    2,  20, 0, 105, 20, 1, 2};
    vecs[2]  = '{0, 103, 10,    2,  10, 0, 105, 20, 1, 3};
    vecs[3]  = '{2, 105, 20,    4,  20, 0, 103, 10, 1, 2};
    vecs[4]  = '{1, 100, 80,    2,  50, 0, 103, 10, 1, 1};
    vecs[5]  = '{1, 100, 5,     2,   0, 1, 103, 10, 1, 1};
    vecs[6]  = '{3, 50,  1,     2,   0, 1, 103, 10, 1, 1};
    vecs[7]  = '{1, 103, 10,  105,  10, 0,   0,  0, 0, 0};
    vecs[8]  = '{0, 0,   5,     2,   5, 0,   0,  5, 1, 1};
    vecs[9]  = '{1, 0,   5,     2,   5, 0,   0,  0, 0, 0};
    vecs[10] = '{0, 255, 3,     2,   3, 0, 255,  3, 1, 1};
    vecs[11] = '{2, 255, 9,   257,   3, 0,   0,  0, 0, 0};

    // Reset and idle.
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    chk("reset busy", longint'(busy), 0);
    chk("reset done", longint'(done), 0);
    chk("reset done_qty", longint'(done_qty), 0);
    chk("reset err", longint'(err), 0);
    chk_best("reset", 0, 0, 0, 0);

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_op(vecs[i].op, vecs[i].p, vecs[i].q, 1'b0);
      chk({tag, " busy"}, r_busy, 1);
      chk({tag, " latency"}, r_lat, vecs[i].lat);
      chk({tag, " done_qty"}, r_dq, vecs[i].dq);
      chk({tag, " err"}, r_err, vecs[i].err);
      chk({tag, " idle at done"}, r_idle, 1);
      chk({tag, " stable before done"}, r_stable, 1);
      chk({tag, " single pulse"}, r_pulse, 1);
      chk_best(tag, vecs[i].bp, vecs[i].bq, vecs[i].bv, vecs[i].cnt);
    end

    // Saturation at level 7 with start pokes while busy.
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      run_op(0, 7, 16'hFFFF, 1'b1);
      if (r_err != 0 || r_dq != 64'hFFFF || r_lat != 2) bad++;
    end
    chk("sat pre-adds clean", bad, 0);
    run_op(0, 7, 16'hFFFF, 1'b1);
    chk("sat err", r_err, 1);
    chk("sat done_qty", r_dq, 255);
    chk("sat latency", r_lat, 2);
    chk_best("sat", 7, LVL_MAXV, 1, 1);

    // Reset in the middle of a scan.
    run_op(0, 200, 1, 1'b0);
    chk_best("pre-scan", 200, 1, 1, 2);
    @(negedge clk_in);
    start = 1'b1; request = 2'd1; price = 8'd200; quantity = 16'd1;
    @(posedge clk_in); #1;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_in); #1;
      if (done) seen = 1;
    end
    chk("mid-scan busy", longint'(busy), 1);
    chk("mid-scan no done", seen, 0);
    @(negedge clk_in); rst_in = 1'b1;
    @(posedge clk_in); #1;
    chk("rst busy", longint'(busy), 0);
    chk("rst done", longint'(done), 0);
    chk("rst done_qty", longint'(done_qty), 0);
    chk("rst err", longint'(err), 0);
    chk_best("rst", 0, 0, 0, 0);
    @(negedge clk_in); rst_in = 1'b0;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk_in); #1;
      if (done || busy) seen = 1;
    end
    chk("no done after rst", seen, 0);
    run_op(1, 7, 1, 1'b0);
    chk("post-rst cleared err", r_err, 1);
    chk("post-rst cleared qty", r_dq, 0);
    run_op(0, 5, 1, 1'b0);
    chk_best("post-rst add", 5, 1, 1, 1);

    // Randomized traffic against the reference array.
    for (int i = 0; i < 256; i++) lvl_m[i] = 0;
    lvl_m[5] = 1;
    for (int n = 0; n < 200; n++) begin
      int sel, op, p, q, old_bp, old_bv, old_cnt, e_bp, e_bv, e_cnt, e_err, e_lat;
      longint old_bq, e_bq, lv, nv, e_dq;
      sel = $urandom_range(0, 9);
      op = (sel < 4) ? 0 : (sel < 6) ? 1 : (sel < 9) ? 2 : 3;
      p = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
      q = (op == 0) ? $urandom_range(1, 100) : $urandom_range(0, 120);
      model_best(old_bp, old_bq, old_bv, old_cnt);
      lv = lvl_m[p]; nv = lv; e_dq = 0; e_err = 0;
      if (op == 0) begin
        nv = lv + q;
        if (nv > LVL_MAXV) begin nv = LVL_MAXV; e_err = 1; end
        e_dq = nv - lv;
      end else if (op == 3) begin
        e_err = 1;
      end else if (lv == 0 || q == 0) begin
        e_err = 1;
      end else begin
        e_dq = (q < lv) ? q : lv;
        nv = lv - e_dq;
      end
      lvl_m[p] = nv;
      model_best(e_bp, e_bq, e_bv, e_cnt);
      e_lat = 2;
      if (lv != 0 && nv == 0 && p == old_bp && old_bp != 0)
        e_lat = 2 + old_bp - e_bp;
      run_op(op, p, q, 1'b0);
      chk("rnd latency", r_lat, e_lat);
      chk("rnd done_qty", r_dq, e_dq);
      chk("rnd err", r_err, e_err);
      chk("rnd stable", r_stable, 1);
      chk_best("rnd", e_bp, e_bq, e_bv, e_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
